mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline. It consumes the EX/MEM pipeline-register outputs and resolves conditional branches into a PC-select and flush. It drives a request/acknowledge data-memory port, stalling the pipeline while an access is outstanding. It also registers results into the MEM/WB boundary for write-back.

## Interface
Parameters:
- AW, 32, data-memory address width.
- DW, 32, data width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- MemtoReg_MEM, MemWrite_MEM, MemRead_MEM, Branch_MEM, RegWrite_MEM, Zero_MEM, Overflow_MEM  in  1 each  EX/MEM control and flags.
- BranchSt_MEM  in  3  branch condition select.
- ALUOut_MEM  in  32  ALU result / memory address.
- ReadRt_MEM  in  32  store data.
- PCBranch_MEM  in  32  branch target.
- WriteReg_MEM  in  5  destination register.
- dm_req  out  1  memory request.
- dm_we  out  1  write enable.
- dm_addr  out  AW  address.
- dm_wdata  out  DW  write data.
- dm_ack  in  1  transfer complete.
- dm_rdata  in  DW  read data, valid with dm_ack.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- pc_src  out  1  select PCBranch.
- pc_branch  out  32  branch target to PC mux.
- flush  out  1  flush IF/ID, ID/EX, EX/MEM.
- MemtoReg_WB, RegWrite_WB  out  1 each  MEM/WB control.
- ReadData_WB, ALUOut_WB  out  32 each  MEM/WB data.
- WriteReg_WB  out  5  MEM/WB destination.
- exc_ovf  out  1  overflow exception pulse.

## Operation
- Branch decision, combinational, gated by Branch_MEM. Taken conditions by BranchSt_MEM:
  - 0 BEQ: Zero.
  - 1 BNE: !Zero.
  - 2 BGEZ: !ALUOut[31].
  - 3 BGTZ: !ALUOut[31] && !Zero.
  - 4 BLEZ: ALUOut[31] || Zero.
  - 5 BLTZ: ALUOut[31].
  - 6 and 7: never taken.
- Branch outputs: pc_src = flush = taken. pc_branch = PCBranch_MEM, passed through.
- Access FSM, states IDLE and WAIT:
  - acc = MemRead_MEM | MemWrite_MEM.
  - IDLE: dm_req = acc. If acc && !dm_ack, go to WAIT. If acc && dm_ack, the access completes zero-wait and the FSM stays in IDLE.
  - WAIT: dm_req = 1. Go to IDLE on dm_ack.
  - dm_we = MemWrite_MEM, dm_addr = ALUOut_MEM[AW-1:0], dm_wdata = ReadRt_MEM. All held stable because upstream is stalled.
  - MemRead and MemWrite both set: the access is treated as a write.
- Stall: mem_stall = dm_req && !dm_ack.
- MEM/WB register, clocked:
  - When !mem_stall, loads MemtoReg, RegWrite, ALUOut, WriteReg and dm_rdata (dm_rdata only when MemRead, else 0).
  - When mem_stall, loads a bubble: RegWrite_WB=0, MemtoReg_WB=0, other fields 0.
- A branch and a memory access are never in the same instruction. No priority between the two paths is required.

## Timing
- Reset: all outputs are 0 and the FSM is in IDLE. dm_req deasserts asynchronously on rst_n low, including mid-WAIT; the pending access is abandoned.
- Load/store latency: one cycle plus N, where N is the cycles from dm_req to dm_ack. Zero-wait memory means no stall.
- dm_req is never deasserted before dm_ack except on reset. dm_ack without dm_req is ignored.
- flush and pc_src are combinational in the cycle the branch occupies MEM.
- MEM/WB outputs appear the cycle after the instruction leaves MEM.

## Configuration
- MEM_OVF_TRAP_EN defined:
  - Overflow_MEM && RegWrite_MEM forces RegWrite_WB=0 on load.
  - Overflow suppresses dm_req.
  - exc_ovf pulses high for one cycle, registered.
- MEM_OVF_TRAP_EN undefined: Overflow_MEM is ignored and exc_ovf is tied to 0.

## Structure
- Shared package mips_pkg holds:
  - BranchSt encodings BR_BEQ through BR_BLTZ.
  - mem_state_t {IDLE, WAIT}.
  - Register-address width constant.
- Sub-module branch_cond: combinational. Inputs BranchSt, Zero, sign; output taken.

## Test plan
- BEQ, Branch=1, BranchSt=0, Zero=1, PCBranch=0x40 -> pc_src=flush=1, pc_branch=0x40. Same with Zero=0 -> both 0.
- BLTZ with ALUOut=0xFFFFFFF0 -> taken. BGTZ with ALUOut=0 and Zero=1 -> not taken.
- Load from address 0x10, dm_ack after 3 cycles, rdata=0xDEADBEEF:
  - mem_stall high for 3 cycles, during which RegWrite_WB=0.
  - Next cycle: ReadData_WB=0xDEADBEEF, RegWrite_WB=1.
- Store with same-cycle dm_ack, addr 0x20, data 0x1234 -> dm_we=1, mem_stall=0, one request cycle.
- rst_n low during WAIT -> dm_req=0 immediately, all WB outputs 0. After release, the FSM is in IDLE.
- Overflow add with RegWrite=1, under MEM_OVF_TRAP_EN -> RegWrite_WB=0, exc_ovf is a 1-cycle pulse. Without the macro -> RegWrite_WB=1, exc_ovf=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: branch condition encodings, MEM-stage
// access FSM state constants and the register-address width.
package mips_pkg;

    localparam int REG_AW = 5;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BGEZ = 3'd2;
    localparam logic [2:0] BR_BGTZ = 3'd3;
    localparam logic [2:0] BR_BLEZ = 3'd4;
    localparam logic [2:0] BR_BLTZ = 3'd5;

    typedef logic [0:0] mem_state_t;
    localparam mem_state_t IDLE = 1'b0;
    localparam mem_state_t WAIT = 1'b1;

endpackage

// File: rtl/mem_stage_branch_cond.sv
// Branch condition evaluator: decides whether the selected MIPS branch
// condition holds, given the ALU zero flag and the result sign bit.
module branch_cond
    import mips_pkg::*;
(
    input  logic [2:0] branch_st,
    input  logic       zero,
    input  logic       sign,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (branch_st)
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            BR_BGEZ: taken = ~sign;
            BR_BGTZ: taken = ~sign & ~zero;
            BR_BLEZ: taken = sign | zero;
            BR_BLTZ: taken = sign;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolution, req/ack data-memory port with stall, and
// the MEM/WB register. Optional overflow trap is enabled by MEM_OVF_TRAP_EN.
module mem_stage
    import mips_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemtoReg_MEM,
    input  logic              MemWrite_MEM,
    input  logic              MemRead_MEM,
    input  logic              Branch_MEM,
    input  logic              RegWrite_MEM,
    input  logic              Zero_MEM,
    input  logic              Overflow_MEM,
    input  logic [2:0]        BranchSt_MEM,
    input  logic [31:0]       ALUOut_MEM,
    input  logic [31:0]       ReadRt_MEM,
    input  logic [31:0]       PCBranch_MEM,
    input  logic [REG_AW-1:0] WriteReg_MEM,
    output logic              dm_req,
    output logic              dm_we,
    output logic [AW-1:0]     dm_addr,
    output logic [DW-1:0]     dm_wdata,
    input  logic              dm_ack,
    input  logic [DW-1:0]     dm_rdata,
    output logic              mem_stall,
    output logic              pc_src,
    output logic [31:0]       pc_branch,
    output logic              flush,
    output logic              MemtoReg_WB,
    output logic              RegWrite_WB,
    output logic [31:0]       ReadData_WB,
    output logic [31:0]       ALUOut_WB,
    output logic [REG_AW-1:0] WriteReg_WB,
    output logic              exc_ovf
);

    logic       acc;
    logic       ovf_trap;
    logic       req_int;
    logic       stall_int;
    logic       cond_true;
    logic       taken;
    mem_state_t state;
    mem_state_t state_nxt;

`ifdef MEM_OVF_TRAP_EN
    assign ovf_trap = Overflow_MEM & RegWrite_MEM;
    assign acc      = (MemRead_MEM | MemWrite_MEM) & ~Overflow_MEM;
`else
    logic ovf_unused;
    assign ovf_unused = Overflow_MEM;
    assign ovf_trap   = 1'b0;
    assign acc        = MemRead_MEM | MemWrite_MEM;
`endif

    branch_cond u_branch_cond (
        .branch_st (BranchSt_MEM),
        .zero      (Zero_MEM),
        .sign      (ALUOut_MEM[31]),
        .taken     (cond_true)
    );

    assign taken     = Branch_MEM & cond_true;
    assign req_int   = (state == WAIT) | acc;
    assign stall_int = req_int & ~dm_ack;

    // Combinational outputs are gated by rst_n so reset drops them at once,
    // including a request abandoned mid-WAIT.
    assign dm_req    = rst_n & req_int;
    assign mem_stall = rst_n & stall_int;
    assign dm_we     = rst_n & MemWrite_MEM;
    assign dm_addr   = rst_n ? ALUOut_MEM[AW-1:0] : '0;
    assign dm_wdata  = rst_n ? DW'(ReadRt_MEM) : '0;
    assign pc_src    = rst_n & taken;
    assign flush     = rst_n & taken;
    assign pc_branch = rst_n ? PCBranch_MEM : 32'd0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc && !dm_ack) state_nxt = WAIT;
            WAIT:    if (dm_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A stalled cycle pushes a bubble into WB so nothing retires twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MemtoReg_WB <= 1'b0;
            RegWrite_WB <= 1'b0;
            ReadData_WB <= 32'd0;
            ALUOut_WB   <= 32'd0;
            WriteReg_WB <= '0;
            exc_ovf     <= 1'b0;
        end else if (stall_int) begin
            MemtoReg_WB <= 1'b0;
            RegWrite_WB <= 1'b0;
            ReadData_WB <= 32'd0;
            ALUOut_WB   <= 32'd0;
            WriteReg_WB <= '0;
            exc_ovf     <= 1'b0;
        end else begin
            MemtoReg_WB <= MemtoReg_MEM;
            RegWrite_WB <= RegWrite_MEM & ~ovf_trap;
            ReadData_WB <= (MemRead_MEM & ~MemWrite_MEM) ? 32'(dm_rdata) : 32'd0;
            ALUOut_WB   <= ALUOut_MEM;
            WriteReg_WB <= WriteReg_MEM;
            exc_ovf     <= ovf_trap;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized
// instructions checked against a behavioural model of the MEM stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemtoReg_MEM, MemWrite_MEM, MemRead_MEM, Branch_MEM;
    logic        RegWrite_MEM, Zero_MEM, Overflow_MEM;
    logic [2:0]  BranchSt_MEM;
    logic [31:0] ALUOut_MEM, ReadRt_MEM, PCBranch_MEM;
    logic [4:0]  WriteReg_MEM;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_stall, pc_src, flush;
    logic [31:0] pc_branch;
    logic        MemtoReg_WB, RegWrite_WB, exc_ovf;
    logic [31:0] ReadData_WB, ALUOut_WB;
    logic [4:0]  WriteReg_WB;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic        br;
        logic [2:0]  bst;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] pcb;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        rw;
        logic [4:0]  wr;
        logic        ovf;
        int          lat;
        logic [31:0] rdata;
    } instr_t;

    mem_stage #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemtoReg_MEM(MemtoReg_MEM), .MemWrite_MEM(MemWrite_MEM),
        .MemRead_MEM(MemRead_MEM), .Branch_MEM(Branch_MEM),
        .RegWrite_MEM(RegWrite_MEM), .Zero_MEM(Zero_MEM),
        .Overflow_MEM(Overflow_MEM), .BranchSt_MEM(BranchSt_MEM),
        .ALUOut_MEM(ALUOut_MEM), .ReadRt_MEM(ReadRt_MEM),
        .PCBranch_MEM(PCBranch_MEM), .WriteReg_MEM(WriteReg_MEM),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_stall(mem_stall), .pc_src(pc_src), .pc_branch(pc_branch),
        .flush(flush), .MemtoReg_WB(MemtoReg_WB), .RegWrite_WB(RegWrite_WB),
        .ReadData_WB(ReadData_WB), .ALUOut_WB(ALUOut_WB),
        .WriteReg_WB(WriteReg_WB), .exc_ovf(exc_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit trapEnabled();
`ifdef MEM_OVF_TRAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Branch rules written directly from the MIPS condition meanings.
    function automatic logic modelTaken(input instr_t s);
        if (!s.br) return 1'b0;
        case (s.bst)
            3'd0:    return s.zero;
            3'd1:    return !s.zero;
            3'd2:    return $signed(s.alu) >= 0;
            3'd3:    return ($signed(s.alu) >= 0) && !s.zero;
            3'd4:    return ($signed(s.alu) < 0) || s.zero;
            3'd5:    return $signed(s.alu) < 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic clearInputs();
        {MemtoReg_MEM, MemWrite_MEM, MemRead_MEM, Branch_MEM} = 4'b0;
        {RegWrite_MEM, Zero_MEM, Overflow_MEM} = 3'b0;
        BranchSt_MEM = 3'd0;
        ALUOut_MEM = 32'd0;
        ReadRt_MEM = 32'd0;
        PCBranch_MEM = 32'd0;
        WriteReg_MEM = 5'd0;
        dm_ack = 1'b0;
        dm_rdata = 32'd0;
    endtask

    task automatic checkWbZero(input string pfx);
        checkOutput({pfx, "_RegWrite_WB"}, 32'(RegWrite_WB), 32'd0);
        checkOutput({pfx, "_MemtoReg_WB"}, 32'(MemtoReg_WB), 32'd0);
        checkOutput({pfx, "_ReadData_WB"}, ReadData_WB, 32'd0);
        checkOutput({pfx, "_ALUOut_WB"}, ALUOut_WB, 32'd0);
        checkOutput({pfx, "_WriteReg_WB"}, 32'(WriteReg_WB), 32'd0);
        checkOutput({pfx, "_exc_ovf"}, 32'(exc_ovf), 32'd0);
    endtask

    // Holds one instruction in MEM until the memory acknowledges, playing the
    // memory side with the instruction's latency, and checks every cycle.
    task automatic applyStimulus(input instr_t s);
        bit access;
        bit taken;
        bit trap;
        int n;
        access = (s.mr || s.mw) && !(trapEnabled() && s.ovf);
        taken  = modelTaken(s);
        trap   = trapEnabled() && s.ovf && s.rw;
        n      = access ? s.lat : 0;
        Branch_MEM = s.br;  BranchSt_MEM = s.bst;  Zero_MEM = s.zero;
        ALUOut_MEM = s.alu; ReadRt_MEM = s.rt;     PCBranch_MEM = s.pcb;
        MemRead_MEM = s.mr; MemWrite_MEM = s.mw;   MemtoReg_MEM = s.m2r;
        RegWrite_MEM = s.rw; WriteReg_MEM = s.wr;  Overflow_MEM = s.ovf;
        for (int c = 0; c <= n; c++) begin
            dm_ack   = access ? (c == n) : 1'($urandom_range(0, 1));
            dm_rdata = (c == n) ? s.rdata : $urandom;
            @(negedge clk);
            checkOutput("dm_req", 32'(dm_req), 32'(access));
            checkOutput("mem_stall", 32'(mem_stall), 32'(access && c < n));
            checkOutput("pc_src", 32'(pc_src), 32'(taken));
            checkOutput("flush", 32'(flush), 32'(taken));
            checkOutput("pc_branch", pc_branch, s.pcb);
            if (access) begin
                checkOutput("dm_we", 32'(dm_we), 32'(s.mw));
                checkOutput("dm_addr", dm_addr, s.alu);
                checkOutput("dm_wdata", dm_wdata, s.rt);
            end
            @(posedge clk);
            #1;
            if (c < n) begin
                checkWbZero("bubble");
            end else begin
                checkOutput("RegWrite_WB", 32'(RegWrite_WB), 32'(s.rw && !trap));
                checkOutput("MemtoReg_WB", 32'(MemtoReg_WB), 32'(s.m2r));
                checkOutput("ReadData_WB", ReadData_WB, (s.mr && !s.mw) ? s.rdata : 32'd0);
                checkOutput("ALUOut_WB", ALUOut_WB, s.alu);
                checkOutput("WriteReg_WB", 32'(WriteReg_WB), 32'(s.wr));
                checkOutput("exc_ovf", 32'(exc_ovf), 32'(trap));
            end
        end
        dm_ack = 1'b0;
    endtask

    function automatic instr_t blankInstr();
        instr_t s;
        s.br = 0; s.bst = 0; s.zero = 0; s.alu = 0; s.rt = 0; s.pcb = 0;
        s.mr = 0; s.mw = 0; s.m2r = 0; s.rw = 0; s.wr = 0; s.ovf = 0;
        s.lat = 0; s.rdata = 0;
        return s;
    endfunction

    function automatic instr_t randomInstr();
        instr_t s;
        int kind;
        s = blankInstr();
        kind = $urandom_range(0, 3);
        s.alu = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
        s.zero = (s.alu == 32'd0);
        s.rt = $urandom; s.pcb = $urandom; s.wr = 5'($urandom);
        s.lat = $urandom_range(0, 4); s.rdata = $urandom;
        case (kind)
            0: begin s.br = 1; s.bst = 3'($urandom); end
            1: begin s.rw = 1'($urandom); s.ovf = ($urandom_range(0, 3) == 0); end
            2: begin s.mr = 1; s.m2r = 1; s.rw = 1; end
            default: begin s.mw = 1; s.mr = ($urandom_range(0, 7) == 0); end
        endcase
        return s;
    endfunction

    initial begin
        instr_t s;
        clearInputs();
        rst_n = 1'b0;
        #3;
        checkOutput("rst_dm_req", 32'(dm_req), 32'd0);
        checkOutput("rst_mem_stall", 32'(mem_stall), 32'd0);
        checkOutput("rst_pc_src", 32'(pc_src), 32'd0);
        checkWbZero("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        s = blankInstr(); s.br = 1; s.bst = 3'd0; s.zero = 1; s.pcb = 32'h40;
        applyStimulus(s);
        s.zero = 0;
        applyStimulus(s);
        s = blankInstr(); s.br = 1; s.bst = 3'd5; s.alu = 32'hFFFF_FFF0; s.pcb = 32'h80;
        applyStimulus(s);
        s = blankInstr(); s.br = 1; s.bst = 3'd3; s.alu = 32'd0; s.zero = 1; s.pcb = 32'h84;
        applyStimulus(s);
        s = blankInstr(); s.mr = 1; s.m2r = 1; s.rw = 1; s.alu = 32'h10; s.wr = 5'd8;
        s.lat = 3; s.rdata = 32'hDEAD_BEEF;
        applyStimulus(s);
        s = blankInstr(); s.mw = 1; s.alu = 32'h20; s.rt = 32'h1234; s.lat = 0;
        applyStimulus(s);
        s = blankInstr(); s.rw = 1; s.ovf = 1; s.alu = 32'h8000_0000; s.wr = 5'd3;
        applyStimulus(s);
        s = blankInstr(); s.rw = 1; s.alu = 32'h5; s.wr = 5'd4;
        applyStimulus(s);

        for (int i = 0; i < 400; i++) applyStimulus(randomInstr());

        // Reset while a load waits on the memory.
        s = blankInstr();
        MemRead_MEM = 1; MemtoReg_MEM = 1; RegWrite_MEM = 1; ALUOut_MEM = 32'h30;
        dm_ack = 0;
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("wait_dm_req", 32'(dm_req), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstwait_dm_req", 32'(dm_req), 32'd0);
        checkOutput("rstwait_mem_stall", 32'(mem_stall), 32'd0);
        checkWbZero("rstwait");
        clearInputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_idle_req", 32'(dm_req), 32'd0);
        s.mw = 1; s.alu = 32'h44; s.rt = 32'hCAFE; s.lat = 1;
        applyStimulus(s);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
